// File: rtl/terminal_writer.sv
// Terminal video RAM write sequencer: byte stream in, cursor, clear and
// one-line scroll out, every RAM access gated by the display-side grant.
module terminal_writer #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 25,
  parameter int         RD_LATENCY     = 2,
  parameter logic [7:0] BLANK_CHAR     = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk36m,
  input  logic        reset_n,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        ram_grant,
  output logic        ram_req,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  typedef enum logic [2:0] {
    RST, IDLE, PUT, CLEAR,
    SC_RD, SC_WAIT, SC_WR, SC_FILL
  } state_e;

  localparam logic [10:0] COLS_A    = 11'(COLS);
  localparam logic [10:0] CELL_LAST = 11'(COLS*ROWS-1);
  localparam logic [10:0] COPY_LAST = 11'(COLS*(ROWS-1)-1);
  localparam logic [10:0] FILL_BASE = 11'(COLS*(ROWS-1));
  localparam logic [6:0]  COL_LAST  = 7'(COLS-1);
  localparam logic [4:0]  ROW_LAST  = 5'(ROWS-1);
  localparam logic [3:0]  LAT_LAST  = 4'(RD_LATENCY-1);

  state_e      state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic [10:0] dst_q, dst_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [3:0]  lat_q, lat_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        is_print, is_cr, is_lf;
  logic        is_bs, is_ff;
  logic        last_col, last_row;
  logic [10:0] cur_addr;

  assign accept   = char_valid && ready_q;
  assign is_print = (char_data >= 8'h20)
                 && (char_data <= 8'h7E);
  assign is_cr    = char_data == 8'h0D;
  assign is_lf    = char_data == 8'h0A;
  assign is_bs    = char_data == 8'h08;
  assign is_ff    = char_data == 8'h0C;
  assign last_col = col_q == COL_LAST;
  assign last_row = row_q == ROW_LAST;
  assign cur_addr = 11'(row_q) * COLS_A
                  + 11'(col_q);

  always_ff @(posedge clk36m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST;
      addr_q  <= '0;
      dst_q   <= '0;
      wdata_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      lat_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dst_q   <= dst_d;
      wdata_q <= wdata_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lat_q   <= lat_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST:
        state_d = CLEAR_ON_RESET ? CLEAR : IDLE;
      IDLE:
        if (accept) begin
          unique case (1'b1)
            is_print: state_d = PUT;
            is_ff:    state_d = CLEAR;
            is_lf:    if (last_row) state_d = SC_RD;
            default:  ;
          endcase
        end
      PUT:
        if (ram_grant)
          state_d = (last_col && last_row) ? SC_RD : IDLE;
      CLEAR, SC_FILL:
        if (ram_grant && addr_q == CELL_LAST)
          state_d = IDLE;
      SC_RD:
        if (ram_grant) state_d = SC_WAIT;
      SC_WAIT:
        if (!ram_grant)
          state_d = SC_RD;
        else if (lat_q == LAT_LAST)
          state_d = SC_WR;
      SC_WR:
        if (ram_grant)
          state_d = (dst_q == COPY_LAST) ? SC_FILL : SC_RD;
      default:
        state_d = RST;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    dst_d   = dst_q;
    wdata_d = wdata_q;
    col_d   = col_q;
    row_d   = row_q;
    lat_d   = lat_q;
    unique case (state_q)
      RST: begin
        addr_d  = '0;
        wdata_d = BLANK_CHAR;
      end
      IDLE:
        if (accept) begin
          unique case (1'b1)
            is_print: begin
              addr_d  = cur_addr;
              wdata_d = char_data;
            end
            is_cr: col_d = '0;
            is_lf:
              if (!last_row) begin
                row_d = row_q + 5'd1;
              end else begin
                dst_d  = '0;
                addr_d = COLS_A;
              end
            is_bs:
              if (col_q != '0) col_d = col_q - 7'd1;
            is_ff: begin
              col_d   = '0;
              row_d   = '0;
              addr_d  = '0;
              wdata_d = BLANK_CHAR;
            end
            default: ;
          endcase
        end
      PUT:
        if (ram_grant) begin
          if (!last_col) begin
            col_d = col_q + 7'd1;
          end else begin
            col_d = '0;
            if (!last_row) begin
              row_d = row_q + 5'd1;
            end else begin
              dst_d  = '0;
              addr_d = COLS_A;
            end
          end
        end
      CLEAR, SC_FILL:
        if (ram_grant && addr_q != CELL_LAST)
          addr_d = addr_q + 11'd1;
      SC_RD:
        if (ram_grant) lat_d = '0;
      SC_WAIT:
        // read data is only trusted after an unbroken run of grants
        if (ram_grant) begin
          lat_d = lat_q + 4'd1;
          if (lat_q == LAT_LAST) begin
            wdata_d = ram_rdata;
            addr_d  = dst_q;
          end
        end
      SC_WR:
        if (ram_grant) begin
          if (dst_q == COPY_LAST) begin
            addr_d  = FILL_BASE;
            wdata_d = BLANK_CHAR;
          end else begin
            dst_d  = dst_q + 11'd1;
            addr_d = dst_q + COLS_A + 11'd1;
          end
        end
      default: ;
    endcase
    ready_d = (state_d == IDLE) && !accept;
    busy_d  = state_d != IDLE;
  end

  always_comb begin
    ram_req = (state_q != RST) && (state_q != IDLE);
    ram_we  = ram_grant
           && (state_q == PUT || state_q == CLEAR
            || state_q == SC_WR || state_q == SC_FILL);
  end

  assign char_ready = ready_q;
  assign busy       = busy_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_terminal_writer.sv
// Bench for terminal_writer: vector table, scroll/reset sequences and a
// random byte stream checked against a screen-array model.
module tb_terminal_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;

  logic        clk36m = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        ram_grant = 1'b1;
  logic        ram_req;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  terminal_writer dut (
    .clk36m     (clk36m),
    .reset_n    (reset_n),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .ram_grant  (ram_grant),
    .ram_req    (ram_req),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk36m = ~clk36m;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, exp);
    end
  endtask

  // RAM with a 2-cycle read pipe; ungranted cycles carry display data
  logic [7:0] mem [0:2047];
  logic [7:0] s1, s2;
  int wr_cnt = 0, fill_cnt = 0, hi_wr = 0;
  int we_viol = 0, rdy_viol = 0, rst_we = 0;
  int last_addr = 0, last_data = 0;
  assign ram_rdata = s2;

  always @(posedge clk36m) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt    <= wr_cnt + 1;
      last_addr <= int'(ram_addr);
      last_data <= int'(ram_wdata);
      if (ram_addr >= 11'd1920 && ram_addr < 11'd2000
          && ram_wdata == 8'h20)
        fill_cnt <= fill_cnt + 1;
      if (ram_addr >= 11'd2000) hi_wr <= hi_wr + 1;
      if (!ram_grant) we_viol <= we_viol + 1;
      if (!reset_n) rst_we <= rst_we + 1;
    end
    s1 <= (ram_grant && ram_req) ? mem[ram_addr] : 8'hEE;
    s2 <= s1;
    if (char_ready && busy) rdy_viol <= rdy_viol + 1;
  end

  // grant pattern: 0 always, 1 three-on/three-off, 2 random
  int gmode = 0;
  int gcnt = 0;
  initial begin
    forever begin
      @(negedge clk36m);
      gcnt++;
      case (gmode)
        1:       ram_grant = ((gcnt / 3) % 2) == 0;
        2:       ram_grant = $urandom_range(0, 3) != 0;
        default: ram_grant = 1'b1;
      endcase
    end
  end

  // reference screen model
  logic [7:0] m_scr [0:CELLS-1];
  int mcol = 0, mrow = 0;

  task automatic m_clear();
    for (int i = 0; i < CELLS; i++) m_scr[i] = 8'h20;
    mcol = 0;
    mrow = 0;
  endtask

  task automatic m_lf();
    if (mrow < ROWS - 1) begin
      mrow++;
    end else begin
      for (int i = 0; i < CELLS - COLS; i++)
        m_scr[i] = m_scr[i + COLS];
      for (int i = CELLS - COLS; i < CELLS; i++)
        m_scr[i] = 8'h20;
    end
  endtask

  task automatic m_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_scr[mrow * COLS + mcol] = b;
      if (mcol == COLS - 1) begin
        mcol = 0;
        m_lf();
      end else begin
        mcol++;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      m_lf();
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      m_clear();
    end
  endtask

  task automatic cmp_ram(input string nm);
    int bad = 0;
    for (int i = 0; i < CELLS; i++)
      if (mem[i] !== m_scr[i]) bad++;
    check(nm, bad, 0);
  endtask

  task automatic wait_ready(input string nm, input int budget);
    int n = 0;
    do begin
      @(negedge clk36m);
      n++;
    end while (!char_ready && n < budget);
    check(nm, int'(char_ready), 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk36m);
    char_data  = b;
    char_valid = 1'b1;
    @(posedge clk36m);
    #1 char_valid = 1'b0;
    m_apply(b);
  endtask

  task automatic send_w(input logic [7:0] b,
                        input int budget = 200);
    send_byte(b);
    wait_ready("ready", budget);
  endtask

  typedef struct {
    logic [7:0] ch;
    int ecol;
    int erow;
    int ewr;
    int eaddr;
    int edata;
  } vec_t;

  vec_t vt [12];
  int w0, f0;

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{8'h41, 1, 0, 1, 0,  'h41};
    vt[1]  = '{8'h0D, 0, 0, 0, 0,  0};
    vt[2]  = '{8'h08, 0, 0, 0, 0,  0};
    vt[3]  = '{8'h42, 1, 0, 1, 0,  'h42};
    vt[4]  = '{8'h43, 2, 0, 1, 1,  'h43};
    vt[5]  = '{8'h08, 1, 0, 0, 0,  0};
    vt[6]  = '{8'h0A, 1, 1, 0, 0,  0};
    vt[7]  = '{8'h01, 1, 1, 0, 0,  0};
    vt[8]  = '{8'h7F, 1, 1, 0, 0,  0};
    vt[9]  = '{8'h7E, 2, 1, 1, 81, 'h7E};
    vt[10] = '{8'h1F, 2, 1, 0, 0,  0};
    vt[11] = '{8'h20, 3, 1, 1, 82, 'h20};

    // reset values and power-up clear
    gmode = 0;
    repeat (3) @(negedge clk36m);
    check("rst_we",    int'(ram_we), 0);
    check("rst_req",   int'(ram_req), 0);
    check("rst_addr",  int'(ram_addr), 0);
    check("rst_wdata", int'(ram_wdata), 0);
    check("rst_ready", int'(char_ready), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_col",   int'(cursor_col), 0);
    check("rst_row",   int'(cursor_row), 0);
    w0 = wr_cnt;
    reset_n = 1'b1;
    for (int n = 0; n < 20 && wr_cnt == w0; n++)
      @(negedge clk36m);
    check("clr_first_addr", last_addr, 0);
    check("clr_first_data", last_data, 'h20);
    wait_ready("clr_ready", 3000);
    check("clr_writes", wr_cnt - w0, CELLS);
    check("clr_col", int'(cursor_col), 0);
    check("clr_row", int'(cursor_row), 0);
    m_clear();
    cmp_ram("clr_img");

    // single-byte vectors from 0,0
    foreach (vt[i]) begin
      w0 = wr_cnt;
      send_w(vt[i].ch);
      check("tbl_col", int'(cursor_col), vt[i].ecol);
      check("tbl_row", int'(cursor_row), vt[i].erow);
      check("tbl_wr", wr_cnt - w0, vt[i].ewr);
      if (vt[i].ewr == 1) begin
        check("tbl_addr", last_addr, vt[i].eaddr);
        check("tbl_data", last_data, vt[i].edata);
      end
    end

    // wrap from the last column of row 3
    send_w(8'h0D);
    send_w(8'h0A);
    send_w(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send_w(8'h78);
    check("nav_col", int'(cursor_col), 79);
    check("nav_row", int'(cursor_row), 3);
    send_w(8'h42);
    check("wrap_addr", last_addr, 319);
    check("wrap_data", last_data, 'h42);
    check("wrap_col", int'(cursor_col), 0);
    check("wrap_row", int'(cursor_row), 4);
    w0 = wr_cnt;
    send_w(8'h08);
    check("bs0_col", int'(cursor_col), 0);
    check("bs0_row", int'(cursor_row), 4);
    check("bs0_wr", wr_cnt - w0, 0);

    // form feed
    w0 = wr_cnt;
    send_w(8'h0C, 3000);
    check("ff_wr", wr_cnt - w0, CELLS);
    check("ff_col", int'(cursor_col), 0);
    check("ff_row", int'(cursor_row), 0);
    cmp_ram("ff_img");

    // scroll with full grant
    send_w(8'h0A);
    send_w(8'h58);
    send_w(8'h0D);
    for (int i = 0; i < 23; i++) send_w(8'h0A);
    check("pre_scroll_row", int'(cursor_row), 24);
    w0 = wr_cnt;
    f0 = fill_cnt;
    send_w(8'h0A, 20000);
    check("scroll_mem0", int'(mem[0]), 'h58);
    check("scroll_fill", fill_cnt - f0, COLS);
    check("scroll_wr", wr_cnt - w0, CELLS);
    check("scroll_col", int'(cursor_col), 0);
    check("scroll_row", int'(cursor_row), 24);
    cmp_ram("scroll_img");

    // scroll with grant toggling every 3 cycles
    gmode = 1;
    send_w(8'h5A);
    send_w(8'h0D);
    w0 = wr_cnt;
    send_w(8'h0A, 40000);
    check("gscroll_wr", wr_cnt - w0, CELLS);
    check("gscroll_row", int'(cursor_row), 24);
    check("gscroll_z", int'(mem[1840]), 'h5A);
    cmp_ram("gscroll_img");

    // random byte stream under random grant
    gmode = 2;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 77) b = 8'h0A;
      else if (r < 81) b = 8'h0D;
      else if (r < 86) b = 8'h08;
      else if (r < 87) b = 8'h0C;
      else             b = 8'($urandom_range(0, 255));
      send_w(b, 40000);
      check("rnd_col", int'(cursor_col), mcol);
      check("rnd_row", int'(cursor_row), mrow);
    end
    cmp_ram("rnd_img");

    // reset in the middle of a scroll
    gmode = 0;
    send_w(8'h0C, 3000);
    for (int i = 0; i < 24; i++) send_w(8'h0A);
    send_byte(8'h0A);
    repeat (400) @(posedge clk36m);
    check("mid_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_we",    int'(ram_we), 0);
    check("mrst_req",   int'(ram_req), 0);
    check("mrst_addr",  int'(ram_addr), 0);
    check("mrst_ready", int'(char_ready), 0);
    check("mrst_busy",  int'(busy), 0);
    check("mrst_row",   int'(cursor_row), 0);
    repeat (3) @(negedge clk36m);
    w0 = wr_cnt;
    reset_n = 1'b1;
    for (int n = 0; n < 20 && wr_cnt == w0; n++)
      @(negedge clk36m);
    check("mrst_first_addr", last_addr, 0);
    check("mrst_first_data", last_data, 'h20);
    wait_ready("mrst_ready_after", 3000);
    check("mrst_clr_wr", wr_cnt - w0, CELLS);
    m_clear();
    cmp_ram("mrst_img");
    check("mrst_col2", int'(cursor_col), 0);

    // global invariants
    check("we_without_grant", we_viol, 0);
    check("we_in_reset", rst_we, 0);
    check("high_addr_writes", hi_wr, 0);
    check("ready_while_busy", rdy_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
